// File: rtl/seven_segment_display_controller_if.sv
// Load/convert handshake between the IO register and the display controller.
// The requester drives load/num; the controller reports busy and overflow.
interface seven_segment_display_controller_if #(
   parameter int BIN_WIDTH = 13
);
   logic                 load;
   logic [BIN_WIDTH-1:0] num;
   logic                 busy;
   logic                 overflow;

   modport master (
      output load,
      output num,
      input  busy,
      input  overflow
   );

   modport slave (
      input  load,
      input  num,
      output busy,
      output overflow
   );
endinterface

// File: rtl/seven_segment_display_controller.sv
// Binary to BCD (shift-add-3) converter with a double-buffered,
// time-multiplexed common-anode seven-segment scanner.
module seven_segment_display_controller #(
   parameter int NUM_DIGITS    = 4,
   parameter int BIN_WIDTH     = 13,
   parameter int REFRESH_BITS  = 18,
   parameter int BLANK_LEADING = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   seven_segment_display_controller_if.slave bus,
   output logic [NUM_DIGITS-1:0]    Anode,
   output logic [6:0]               LED_out
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int IDX_W =
      (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W =
      (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MSD =
      IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(BIN_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      UPDATE
   } state_t;

   state_t                  state_q;
   logic [BIN_WIDTH-1:0]    shift_q;
   logic [BCD_W-1:0]        bcd_q;
   logic [BCD_W-1:0]        bcd_corr;
   logic [BCD_W-1:0]        disp_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    ovf_scr_q;
   logic                    overflow_q;
   logic                    busy_q;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [IDX_W-1:0]        idx_q;
   logic [IDX_W-1:0]        sel;
   logic [NUM_DIGITS-1:0]   anode_q;
   logic [NUM_DIGITS-1:0]   anode_d;
   logic [6:0]              led_q;
   logic [6:0]              led_d;
   logic [3:0]              digit;
   logic                    lead;
   logic                    blank_sel;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      bcd_corr = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5)
            bcd_corr[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   // idx_q counts scan order (0 = MSD); sel is the physical digit.
   always_comb begin
      sel       = IDX_MSD - idx_q;
      digit     = 4'd0;
      lead      = 1'b1;
      blank_sel = 1'b0;
      anode_d   = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lead = lead & (disp_q[i*4 +: 4] == 4'd0);
         if (IDX_W'(i) == sel) begin
            digit      = disp_q[i*4 +: 4];
            anode_d[i] = 1'b0;
            blank_sel  = lead && (i != 0) &&
                         (BLANK_LEADING != 0);
         end
      end
      if (overflow_q)
         led_d = 7'b1111110;
      else if (blank_sel)
         led_d = 7'b1111111;
      else
         led_d = seg7(digit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         disp_q     <= '0;
         cnt_q      <= '0;
         ovf_scr_q  <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         refresh_q  <= '0;
         idx_q      <= '0;
         anode_q    <= '1;
         led_q      <= 7'b1111111;
      end else begin
         refresh_q <= refresh_q + REFRESH_BITS'(1);
         if (&refresh_q)
            idx_q <= (idx_q == IDX_MSD) ?
                     '0 : idx_q + IDX_W'(1);
         anode_q <= anode_d;
         led_q   <= led_d;
         unique case (state_q)
            IDLE: begin
               if (bus.load) begin
                  shift_q   <= bus.num;
                  bcd_q     <= '0;
                  ovf_scr_q <= 1'b0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= CONVERT;
               end
            end
            CONVERT: begin
               // A 1 leaving the top digit means the value needs more digits.
               {bcd_q, shift_q} <= {bcd_corr, shift_q} << 1;
               ovf_scr_q <= ovf_scr_q | bcd_corr[BCD_W-1];
               cnt_q     <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST)
                  state_q <= UPDATE;
            end
            UPDATE: begin
               disp_q     <= bcd_q;
               overflow_q <= ovf_scr_q;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
   assign Anode        = anode_q;
   assign LED_out      = led_q;

endmodule

// File: doc/seven_segment_display_controller.md
Name: seven_segment_display_controller

Overview:
- Parametrised successor to the four-digit seven-segment driver.
- Converts an unsigned binary value to BCD with a sequential shift-add-3 (double-dabble) engine and a load/busy handshake.
- Holds the result in a double-buffered display register and time-multiplexes NUM_DIGITS common-anode digits.
- Adds leading-zero blanking, an overflow indication, and registered outputs.
- Sits between the core's debug/IO register and the board's anode and segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 1..8, need not be a power of two.
- BIN_WIDTH, 13: width of the binary input.
- REFRESH_BITS, 18: each digit stays lit for 2^REFRESH_BITS clk cycles.
- BLANK_LEADING, 1: 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  request to convert num; sampled only when busy=0.
- num  input  BIN_WIDTH  unsigned binary value; captured on an accepted load.
- busy  output  1  conversion in progress; load is ignored while high.
- overflow  output  1  displayed value does not fit in NUM_DIGITS decimal digits.
- Anode  output  NUM_DIGITS  active-low digit enables; Anode[NUM_DIGITS-1] is the most significant digit.
- LED_out  output  7  active-low segments; bit6=a … bit0=g.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - busy=0, overflow=0, Anode all 1s, LED_out=7'b1111111.
  - FSM=IDLE; display register all zero; refresh counter=0; scan index=MSD.
  - Reset mid-conversion aborts the conversion and discards it; the display register is also cleared.
- FSM states and transitions:
  - IDLE: load=1 captures num into the shift register, clears the BCD accumulator and the overflow scratch flag, and moves to CONVERT. busy=1 from the next cycle.
  - CONVERT: exactly BIN_WIDTH cycles. Each cycle, every BCD digit ≥5 gets +3, then {BCD, shift} shifts left by one.
    - The scratch overflow flag sets if the MSB of the top BCD digit is 1 after correction, i.e. before the bit is shifted out.
    - After the BIN_WIDTH-th shift, go to UPDATE.
  - UPDATE: one cycle. Copy the BCD accumulator to the display register and the scratch flag to overflow; go to IDLE. busy=0 after this edge.
- Timing and handshake:
  - busy is high for exactly BIN_WIDTH+1 cycles per accepted load.
  - The new value is visible on outputs within one scan slot after busy falls.
  - load while busy=1 is dropped, not queued, including a load in the UPDATE cycle.
  - load held high continuously re-triggers every BIN_WIDTH+2 cycles.
  - The display register changes only in UPDATE, so the display never shows partial results.
- Scan:
  - The refresh counter (REFRESH_BITS wide) free-runs.
  - On wrap, the scan index advances MSD → LSD, then wraps from LSD back to MSD (modulo NUM_DIGITS).
  - Exactly one Anode bit is low at a time. Anode and LED_out are registered, updating one cycle after the index changes.
- Segment encoding (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other code shows 1111111.
- Blanking (BLANK_LEADING=1):
  - A digit is blank if it and all more-significant digits are zero.
  - The LSD is never blanked, so value 0 shows a single "0".
  - A blanked digit drives LED_out=1111111; Anode still selects it to keep constant duty.
- Overflow:
  - When overflow=1, every digit shows "-" (LED_out=1111110) regardless of blanking.
  - Overflow clears on the next conversion that fits.
- Arithmetic: the accumulator is NUM_DIGITS×4 bits. If BIN_WIDTH is small, the upper digits are naturally zero; no width truncation warnings are acceptable.

Test Plan:
- Use REFRESH_BITS=2 in simulation.
- Reset, then sample all outputs. Required: busy=0, overflow=0.
  - The first scan shows the LSD with LED_out=0000001.
  - The other digits are blanked (LED_out=1111111).
  - Anode cycles 0111, 1011, 1101, 1110.
- load=1, num=13'd1234. Required:
  - busy high exactly 14 cycles.
  - Afterwards the digits MSD→LSD show 1001111, 0010010, 0000110, 1001100.
  - overflow=0.
- num=13'd7 with BLANK_LEADING=1. Required:
  - Thousands, hundreds and tens blank.
  - Ones shows 0001111.
  - With BLANK_LEADING=0, the display shows 0,0,0,7.
- num=13'd8191, NUM_DIGITS=4. Required:
  - Digits show 8,1,9,1 and overflow=0.
  - Repeat with NUM_DIGITS=3: overflow=1 and all three digits show 1111110.
  - Then load 13'd42: overflow clears and the display shows blank,4,2.
- Protocol edge cases, with 1234 then 5678. Required:
  - Load 5678 issued 5 cycles into the 1234 conversion: ignored; 1234 is displayed.
  - Load issued in the UPDATE cycle: ignored.
  - Assert rst at CONVERT cycle 6: busy=0 next cycle and the display returns to a single "0".
- NUM_DIGITS=6, BIN_WIDTH=20, num=20'd999999. Required:
  - Six digits show 9, each giving LED_out=0000100.
  - The scan wraps from index 5 back to 0.
  - busy is high for 21 cycles.
